mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 14 +
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the request side; the unit returns busy and the HI/LO registers.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, MDUop, A, B, input busy, HI, LO);
  modport slave  (input start, MDUop, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit owning the HI/LO registers.
// Results are computed at acceptance, held pending, and committed when the countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
  localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   hi, hi_next, lo, lo_next;
  logic [31:0]   pend_hi, pend_hi_next, pend_lo, pend_lo_next;
  logic          pend_wr, pend_wr_next;

  // One 64x64 multiplier serves both signednesses: sign- or zero-extend, keep the low 64 bits.
  logic        signed_mul;
  logic [63:0] mul_a, mul_b, product;

  assign signed_mul = (mdu.MDUop == OP_MULT);
  assign mul_a      = {{32{signed_mul & mdu.A[31]}}, mdu.A};
  assign mul_b      = {{32{signed_mul & mdu.B[31]}}, mdu.B};
  assign product    = mul_a * mul_b;

  // Signed divide works on magnitudes; MIN/-1 falls out as 0x80000000 with remainder 0.
  logic        signed_div, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;

  assign signed_div = (mdu.MDUop == OP_DIV);
  assign a_neg      = signed_div & mdu.A[31];
  assign b_neg      = signed_div & mdu.B[31];
  assign a_mag      = a_neg ? -mdu.A : mdu.A;
  assign b_mag      = b_neg ? -mdu.B : mdu.B;
  assign div_zero   = (mdu.B == 32'd0);
  assign b_safe     = div_zero ? 32'd1 : b_mag;
  assign uq         = a_mag / b_safe;
  assign ur         = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? -uq : uq;
  assign rem        = a_neg ? -ur : ur;

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    pend_wr_next = pend_wr;

    unique case (state)
      IDLE: begin
        if (mdu.start) begin
          case (mdu.MDUop)
            OP_MULT, OP_MULTU: begin
              pend_hi_next = product[63:32];
              pend_lo_next = product[31:0];
              pend_wr_next = 1'b1;
              cnt_next     = MULT_LOAD;
              state_next   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_next = rem;
              pend_lo_next = quot;
              pend_wr_next = !div_zero;
              cnt_next     = DIV_LOAD;
              state_next   = RUN;
            end
            OP_MTHI: hi_next = mdu.A;
            OP_MTLO: lo_next = mdu.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (pend_wr) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, as flops do.
      state   <= state_next;
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      pend_wr <= pend_wr_next;
    end
  end

  assign mdu.busy = (state == RUN);
  assign mdu.HI   = hi;
  assign mdu.LO   = lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of single operations plus hand-written
// sequences for overlapping starts, back-to-back acceptance, and mid-run reset.
module tb_mult_div_unit;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  mult_div_unit_if mdu ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  res_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] hi, input logic [31:0] lo);
    res_t r;
    r.hi = hi;
    r.lo = lo;
    sb.push_back(r);
  endtask

  task automatic sb_check(input string name);
    res_t r;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, no expected result", name);
    end else begin
      r = sb.pop_front();
      check({name, " HI"}, mdu.HI, r.hi);
      check({name, " LO"}, mdu.LO, r.lo);
      model_hi = r.hi;
      model_lo = r.lo;
    end
  endtask

  // Counts busy cycles after the accepting edge; HI/LO must hold the old values meanwhile.
  task automatic wait_done(output int n, output logic stable);
    n      = 0;
    stable = 1'b1;
    while (mdu.busy && n < 100) begin
      n++;
      if (mdu.HI !== model_hi || mdu.LO !== model_lo) stable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input vec_t v);
    int   n;
    logic stable;
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.MDUop = v.op;
    mdu.A     = v.a;
    mdu.B     = v.b;
    sb_push(v.exp_hi, v.exp_lo);
    @(posedge clk); #1;
    mdu.start = 1'b0;
    mdu.A     = $urandom;
    mdu.B     = $urandom;
    wait_done(n, stable);
    check({v.name, " busy cycles"}, 32'(n), 32'(v.exp_cycles));
    check({v.name, " stable in run"}, 32'(stable), 32'd1);
    sb_check(v.name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    logic stable;
    logic clean;

    vecs.push_back('{"MULT -2*3",      OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{"MULTU max*2",    OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5});
    vecs.push_back('{"DIV -7/2",       OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"DIVU 7/0",       OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"DIV min/-1",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
    vecs.push_back('{"DIVU 100/7",     OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10});
    vecs.push_back('{"DIV 7/-2",       OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{"MTHI",           OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0});
    vecs.push_back('{"MTLO",           OP_MTLO,  32'hCAFEBABE, 32'd9,        32'h12345678, 32'hCAFEBABE, 0});
    vecs.push_back('{"noop 7",         4'd7,     32'd1,        32'd1,        32'h12345678, 32'hCAFEBABE, 0});
    vecs.push_back('{"noop 15",        4'd15,    32'd2,        32'd3,        32'h12345678, 32'hCAFEBABE, 0});
    vecs.push_back('{"MULT maxpos^2",  OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5});
    vecs.push_back('{"MULT -1*-1",     OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5});
    vecs.push_back('{"MULTU max^2",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
    vecs.push_back('{"DIV -8/-3",      OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10});
    vecs.push_back('{"DIV 0/0",        OP_DIV,   32'd0,        32'd0,        32'hFFFFFFFE, 32'h00000002, 10});
    vecs.push_back('{"DIVU max/16",    OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10});

    mdu.start = 1'b0;
    mdu.MDUop = 4'd0;
    mdu.A     = '0;
    mdu.B     = '0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(mdu.busy), 32'd0);
    check("reset HI", mdu.HI, 32'd0);
    check("reset LO", mdu.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // A DIV request in cycle 2 of a running MULT must be dropped.
    @(negedge clk);
    mdu.start = 1'b1; mdu.MDUop = OP_MULT; mdu.A = 32'd3; mdu.B = 32'd5;
    sb_push(32'd0, 32'd15);
    @(posedge clk); #1;
    mdu.start = 1'b0;
    n = 0;
    stable = 1'b1;
    while (mdu.busy && n < 100) begin
      n++;
      if (mdu.HI !== model_hi || mdu.LO !== model_lo) stable = 1'b0;
      if (n == 2) begin
        mdu.start = 1'b1; mdu.MDUop = OP_DIV; mdu.A = 32'd100; mdu.B = 32'd3;
      end else begin
        mdu.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("overlap busy cycles", 32'(n), 32'd5);
    check("overlap stable in run", 32'(stable), 32'd1);
    sb_check("overlap MULT");
    @(posedge clk); #1;
    check("overlap DIV ignored busy", 32'(mdu.busy), 32'd0);
    check("overlap DIV ignored LO", mdu.LO, 32'd15);

    // Start held high through completion: accepted only on the edge after busy falls.
    @(negedge clk);
    mdu.start = 1'b1; mdu.MDUop = OP_MULT; mdu.A = 32'd2; mdu.B = 32'd3;
    sb_push(32'd0, 32'd6);
    @(posedge clk); #1;
    mdu.MDUop = OP_MTLO; mdu.A = 32'hABCD0123; mdu.B = 32'hFFFFFFFF;
    wait_done(n, stable);
    check("held start busy cycles", 32'(n), 32'd5);
    check("held start stable in run", 32'(stable), 32'd1);
    sb_check("held start MULT");
    sb_push(32'd0, 32'hABCD0123);
    @(posedge clk); #1;
    mdu.start = 1'b0;
    sb_check("held start MTLO");
    check("held start MTLO busy", 32'(mdu.busy), 32'd0);

    // Reset in cycle 3 of a DIV clears everything at once and discards the result.
    @(negedge clk);
    mdu.start = 1'b1; mdu.MDUop = OP_DIV; mdu.A = 32'd100; mdu.B = 32'd3;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid-run busy before reset", 32'(mdu.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset busy", 32'(mdu.busy), 32'd0);
    check("async reset HI", mdu.HI, 32'd0);
    check("async reset LO", mdu.LO, 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    clean = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (mdu.busy !== 1'b0 || mdu.HI !== 32'd0 || mdu.LO !== 32'd0) clean = 1'b0;
    end
    check("no update after reset", 32'(clean), 32'd1);

    // First acceptance happens on the first edge with reset released and start high.
    @(negedge clk);
    reset     = 1'b0;
    mdu.start = 1'b1; mdu.MDUop = OP_MTHI; mdu.A = 32'h55AA55AA;
    @(posedge clk); #1;
    check("start during reset HI", mdu.HI, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb_push(32'h55AA55AA, 32'd0);
    @(posedge clk); #1;
    mdu.start = 1'b0;
    sb_check("first accept after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
